// File: rtl/regfile_writeback_if.sv
// Producer-side bundle for the writeback stage: single-cycle ALU results plus the
// valid/ready offer channel for multi-cycle (load/mult) results.
interface regfile_writeback_if;
  logic        alu_valid;
  logic [4:0]  alu_reg;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_reg;
  logic [31:0] mem_data;

  modport master (
    output alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
    input  mem_ready
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
    output mem_ready
  );
endinterface

// File: rtl/regfile_writeback.sv
// Merges ALU and queued mem results onto one registered regfile write port; ALU writes land 1 cycle after
// the edge, mem writes 2 cycles after accept. ALU always wins, and mem_ready drops only when the queue is full or during clr.
module regfile_writeback #(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                clr,
  regfile_writeback_if.slave  bus,
  output logic                write,
  output logic [4:0]          write_reg,
  output logic [31:0]         write_data,
  output logic [31:0]         busy_mask,
  output logic [2:0]          queue_count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [2:0]             count_q, count_d;
  logic [DEPTH-1:0]       vld_q, vld_d;
  logic [DEPTH-1:0]       live_q, live_d;
  logic [DEPTH-1:0][4:0]  reg_q, reg_d;
  logic [DEPTH-1:0][31:0] data_q, data_d;
  logic                   write_q, write_d;
  logic [4:0]             wreg_q, wreg_d;
  logic [31:0]            wdata_q, wdata_d;
  logic                   push, pop, kill;

  assign bus.mem_ready = (count_q < 3'(DEPTH)) && !clr;
  assign push          = bus.mem_valid && bus.mem_ready;
  assign pop           = !bus.alu_valid && (count_q != 3'd0);
  assign kill          = bus.alu_valid && (bus.alu_reg != 5'd0);

  // Kill only looks at slots already valid, so an entry pushed on the same edge survives.
  always_comb begin
    vld_d    = vld_q;
    live_d   = live_q;
    reg_d    = reg_q;
    data_d   = data_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (kill && vld_q[i] && (reg_q[i] == bus.alu_reg)) begin
        live_d[i] = 1'b0;
      end
    end
    if (pop) begin
      vld_d[rd_ptr_q]  = 1'b0;
      live_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = rd_ptr_q + PW'(1);
    end
    if (push) begin
      vld_d[wr_ptr_q]  = 1'b1;
      live_d[wr_ptr_q] = (bus.mem_reg != 5'd0);
      reg_d[wr_ptr_q]  = bus.mem_reg;
      data_d[wr_ptr_q] = bus.mem_data;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    write_d = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (bus.alu_valid) begin
      write_d = (bus.alu_reg != 5'd0);
      wreg_d  = bus.alu_reg;
      wdata_d = bus.alu_data;
    end else if (pop) begin
      write_d = live_q[rd_ptr_q];
      wreg_d  = reg_q[rd_ptr_q];
      wdata_d = data_q[rd_ptr_q];
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && live_q[i]) begin
        busy_mask[reg_q[i]] = 1'b1;
      end
    end
    busy_mask[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
      live_q   <= '0;
      write_q  <= 1'b0;
      wreg_q   <= '0;
      wdata_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      vld_q    <= vld_d;
      live_q   <= live_d;
      write_q  <= write_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
    end
  end

  // Payload storage is qualified by vld_q, so it needs no reset.
  always_ff @(posedge clk) begin
    reg_q  <= reg_d;
    data_q <= data_d;
  end

  assign write       = write_q;
  assign write_reg   = wreg_q;
  assign write_data  = wdata_q;
  assign queue_count = count_q;
endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: a behavioural queue model feeds a scoreboard of expected
// writes, and directed scenario tasks check the specific cases inline.
module tb_regfile_writeback;
  logic        clk = 1'b0;
  logic        clr;
  logic        write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [31:0] busy_mask;
  logic [2:0]  queue_count;
  int          vectors = 0;
  int          miscompares = 0;

  regfile_writeback_if bus ();

  regfile_writeback #(.DEPTH(4)) dut (
    .clk         (clk),
    .clr         (clr),
    .bus         (bus),
    .write       (write),
    .write_reg   (write_reg),
    .write_data  (write_data),
    .busy_mask   (busy_mask),
    .queue_count (queue_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic live; logic [4:0] r; logic [31:0] d; } ent_t;
  typedef struct { logic w; logic [4:0] r; logic [31:0] d; } exp_t;
  ent_t mq[$];
  exp_t sb[$];

  // Reference model: updates its own queue at each edge, pushes the expected write.
  always @(posedge clk) begin : model
    exp_t e;
    ent_t h;
    ent_t n;
    logic do_push;
    do_push = bus.mem_valid && (mq.size() < 4) && !clr;
    e.w = 1'b0; e.r = '0; e.d = '0;
    if (clr) begin
      mq.delete();
    end else begin
      if (bus.alu_valid) begin
        e.w = (bus.alu_reg != 5'd0); e.r = bus.alu_reg; e.d = bus.alu_data;
        if (bus.alu_reg != 5'd0) foreach (mq[i]) if (mq[i].r == bus.alu_reg) mq[i].live = 1'b0;
      end else if (mq.size() > 0) begin
        h = mq.pop_front();
        e.w = h.live; e.r = h.r; e.d = h.d;
      end
      if (do_push) begin
        n.live = (bus.mem_reg != 5'd0); n.r = bus.mem_reg; n.d = bus.mem_data;
        mq.push_back(n);
      end
    end
    sb.push_back(e);
  end

  always @(posedge clk) begin : monitor
    exp_t e;
    logic [31:0] bm;
    logic        rdy;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if (write !== e.w) begin miscompares++; $display("FAIL sb_write t=%0t got %b want %b", $time, write, e.w); end
      if (e.w) begin
        vectors++;
        if (write_reg !== e.r || write_data !== e.d) begin
          miscompares++; $display("FAIL sb_wdat t=%0t got r%0d %h want r%0d %h", $time, write_reg, write_data, e.r, e.d);
        end
      end
      bm = '0;
      foreach (mq[i]) if (mq[i].live) bm[mq[i].r] = 1'b1;
      bm[0] = 1'b0;
      vectors++;
      if (busy_mask !== bm) begin miscompares++; $display("FAIL sb_busy t=%0t got %h want %h", $time, busy_mask, bm); end
      vectors++;
      if (queue_count !== 3'(mq.size())) begin miscompares++; $display("FAIL sb_count t=%0t got %0d want %0d", $time, queue_count, mq.size()); end
      rdy = (mq.size() < 4) && !clr;
      vectors++;
      if (bus.mem_ready !== rdy) begin miscompares++; $display("FAIL sb_ready t=%0t got %b want %b", $time, bus.mem_ready, rdy); end
    end
  end

  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md);
    @(negedge clk);
    bus.alu_valid = av; bus.alu_reg = ar; bus.alu_data = ad;
    bus.mem_valid = mv; bus.mem_reg = mr; bus.mem_data = md;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #2;
    vectors++; if (write !== 1'b0) begin miscompares++; $display("FAIL rst_write got %b want 0", write); end
    vectors++; if (write_reg !== 5'd0 || write_data !== 32'd0) begin miscompares++; $display("FAIL rst_wdat got %0d %h want 0 0", write_reg, write_data); end
    vectors++; if (queue_count !== 3'd0) begin miscompares++; $display("FAIL rst_count got %0d want 0", queue_count); end
    vectors++; if (busy_mask !== 32'd0) begin miscompares++; $display("FAIL rst_busy got %h want 0", busy_mask); end
    vectors++; if (bus.mem_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready_in_clr got %b want 0", bus.mem_ready); end
    @(negedge clk);
    clr = 1'b0;
    #1;
    vectors++; if (bus.mem_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready_after got %b want 1", bus.mem_ready); end
    vectors++; if (write !== 1'b0) begin miscompares++; $display("FAIL rst_write_after got %b want 0", write); end
  endtask

  task automatic test_alu();
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    vectors++; if (write !== 1'b1 || write_reg !== 5'd5 || write_data !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL alu_write got %b r%0d %h want 1 r5 deadbeef", write, write_reg, write_data); end
    idle();
    vectors++; if (write !== 1'b0) begin miscompares++; $display("FAIL alu_next got %b want 0", write); end
    vectors++; if (write_reg !== 5'd5 || write_data !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL idle_hold got r%0d %h want r5 deadbeef", write_reg, write_data); end
    drive(1'b1, 5'd0, 32'h1111, 1'b0, 5'd0, 32'd0);
    vectors++; if (write !== 1'b0) begin miscompares++; $display("FAIL alu_reg0 got %b want 0", write); end
  endtask

  task automatic test_mem_single();
    @(negedge clk);
    bus.alu_valid = 1'b0; bus.mem_valid = 1'b1; bus.mem_reg = 5'd7; bus.mem_data = 32'h12345678;
    #1;
    vectors++; if (bus.mem_ready !== 1'b1) begin miscompares++; $display("FAIL mem_ready_empty got %b want 1", bus.mem_ready); end
    @(posedge clk);
    #2;
    vectors++; if (busy_mask !== 32'h80 || queue_count !== 3'd1 || write !== 1'b0) begin
      miscompares++; $display("FAIL mem_accept got busy %h cnt %0d w %b want 80 1 0", busy_mask, queue_count, write); end
    idle();
    vectors++; if (write !== 1'b1 || write_reg !== 5'd7 || write_data !== 32'h12345678) begin
      miscompares++; $display("FAIL mem_write got %b r%0d %h want 1 r7 12345678", write, write_reg, write_data); end
    vectors++; if (busy_mask !== 32'd0 || queue_count !== 3'd0) begin
      miscompares++; $display("FAIL mem_popped got busy %h cnt %0d want 0 0", busy_mask, queue_count); end
  endtask

  task automatic test_full();
    for (int i = 1; i <= 4; i++) drive(1'b1, 5'd20, 32'h100 + i, 1'b1, 5'(i), 32'hA0 + i);
    vectors++; if (queue_count !== 3'd4 || bus.mem_ready !== 1'b0 || busy_mask !== 32'h1E) begin
      miscompares++; $display("FAIL full got cnt %0d rdy %b busy %h want 4 0 1e", queue_count, bus.mem_ready, busy_mask); end
    drive(1'b1, 5'd20, 32'h200, 1'b1, 5'd5, 32'hBAD);
    vectors++; if (queue_count !== 3'd4 || busy_mask !== 32'h1E) begin
      miscompares++; $display("FAIL full_hold got cnt %0d busy %h want 4 1e", queue_count, busy_mask); end
    for (int i = 1; i <= 4; i++) begin
      idle();
      vectors++; if (write !== 1'b1 || write_reg !== 5'(i) || write_data !== 32'hA0 + i) begin
        miscompares++; $display("FAIL drain%0d got %b r%0d %h want 1 r%0d %h", i, write, write_reg, write_data, i, 32'hA0 + i); end
      if (i == 1) begin
        vectors++; if (bus.mem_ready !== 1'b1 || queue_count !== 3'd3) begin
          miscompares++; $display("FAIL full_release got rdy %b cnt %0d want 1 3", bus.mem_ready, queue_count); end
      end
    end
  endtask

  task automatic test_kill();
    drive(1'b1, 5'd10, 32'd1, 1'b1, 5'd9, 32'h99);
    drive(1'b1, 5'd9, 32'hAA, 1'b1, 5'd9, 32'h77);
    vectors++; if (write !== 1'b1 || write_reg !== 5'd9 || write_data !== 32'hAA) begin
      miscompares++; $display("FAIL kill_alu got %b r%0d %h want 1 r9 aa", write, write_reg, write_data); end
    vectors++; if (busy_mask !== 32'h200 || queue_count !== 3'd2) begin
      miscompares++; $display("FAIL kill_same_edge got busy %h cnt %0d want 200 2", busy_mask, queue_count); end
    drive(1'b1, 5'd9, 32'hBB, 1'b0, 5'd0, 32'd0);
    vectors++; if (busy_mask !== 32'd0) begin miscompares++; $display("FAIL kill_busy got %h want 0", busy_mask); end
    idle();
    vectors++; if (write !== 1'b0 || queue_count !== 3'd1) begin
      miscompares++; $display("FAIL kill_pop1 got w %b cnt %0d want 0 1", write, queue_count); end
    idle();
    vectors++; if (write !== 1'b0 || queue_count !== 3'd0) begin
      miscompares++; $display("FAIL kill_pop2 got w %b cnt %0d want 0 0", write, queue_count); end
  endtask

  task automatic test_reg0();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h123);
    vectors++; if (queue_count !== 3'd1 || busy_mask !== 32'd0) begin
      miscompares++; $display("FAIL reg0_push got cnt %0d busy %h want 1 0", queue_count, busy_mask); end
    idle();
    vectors++; if (write !== 1'b0 || queue_count !== 3'd0) begin
      miscompares++; $display("FAIL reg0_pop got w %b cnt %0d want 0 0", write, queue_count); end
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd16, 32'h500);
    for (int k = 1; k <= 6; k++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(16 + k), 32'h500 + k);
      vectors++; if (write !== 1'b1 || write_reg !== 5'(15 + k) || write_data !== 32'h4FF + k || queue_count !== 3'd1) begin
        miscompares++; $display("FAIL b2b%0d got %b r%0d %h cnt %0d want 1 r%0d %h 1", k, write, write_reg, write_data, queue_count, 15 + k, 32'h4FF + k); end
    end
    idle();
    vectors++; if (write !== 1'b1 || write_reg !== 5'd22 || write_data !== 32'h506) begin
      miscompares++; $display("FAIL b2b_last got %b r%0d %h want 1 r22 506", write, write_reg, write_data); end
  endtask

  task automatic test_clr_mid();
    for (int i = 0; i < 3; i++) drive(1'b1, 5'd20, 32'(i), 1'b1, 5'(11 + i), 32'h300 + i);
    vectors++; if (queue_count !== 3'd3 || busy_mask !== 32'h3800) begin
      miscompares++; $display("FAIL clr_pre got cnt %0d busy %h want 3 3800", queue_count, busy_mask); end
    @(negedge clk);
    clr = 1'b1; bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
    @(posedge clk);
    #2;
    vectors++; if (queue_count !== 3'd0 || busy_mask !== 32'd0 || write !== 1'b0) begin
      miscompares++; $display("FAIL clr_mid got cnt %0d busy %h w %b want 0 0 0", queue_count, busy_mask, write); end
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idle();
      vectors++; if (write !== 1'b0) begin miscompares++; $display("FAIL clr_ghost%0d got %b want 0", i, write); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      clr           = ($urandom_range(0, 49) == 0);
      bus.alu_valid = ($urandom_range(0, 9) < 4);
      bus.alu_reg   = 5'($urandom_range(0, 7));
      bus.alu_data  = $urandom;
      bus.mem_valid = ($urandom_range(0, 9) < 6);
      bus.mem_reg   = 5'($urandom_range(0, 7));
      bus.mem_data  = $urandom;
    end
    @(negedge clk);
    clr = 1'b0;
    repeat (6) idle();
  endtask

  initial begin
    clr = 1'b1;
    bus.alu_valid = 1'b0; bus.alu_reg = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_reg = '0; bus.mem_data = '0;
    test_reset();
    test_alu();
    test_mem_single();
    test_full();
    test_kill();
    test_reg0();
    test_back_to_back();
    test_clr_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/regfile_writeback.md
REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 Port clk  in  1  system clock; all state updates on rising edge.
REQ-002 Port clr  in  1  synchronous active-high reset; sampled on rising clk edge.
REQ-003 Port alu_valid  in  1  single-cycle pipeline result present this cycle; never stalled.
REQ-004 Port alu_reg  in  5  destination register of ALU result.
REQ-005 Port alu_data  in  32  ALU result value.
REQ-006 Port mem_valid  in  1  multi-cycle (load/mult) result offered.
REQ-007 Port mem_ready  out  1  queue can accept mem result this cycle.
REQ-008 Port mem_reg  in  5  destination register of mem result.
REQ-009 Port mem_data  in  32  mem result value.
REQ-010 Port write  out  1  register-file write enable, registered.
REQ-011 Port write_reg  out  5  register-file write address, registered.
REQ-012 Port write_data  out  32  register-file write data, registered.
REQ-013 Port busy_mask  out  32  bit r = 1 while a live queued entry targets register r; bit 0 always 0.
REQ-014 Port queue_count  out  3  occupied queue slots, 0..4, live or killed.
REQ-015 Parameter DEPTH, default 4, queue slots; only 4 is required to be supported.

Function
REQ-016 Single write port: ALU has absolute priority; the mem queue drains only in cycles with alu_valid = 0.
REQ-017 ALU path: alu_valid at edge N loads the output registers; write = 1 during cycle N+1 with alu_reg/alu_data; if alu_reg = 0 then write = 0.
REQ-018 Mem handshake: transfer occurs at an edge where mem_valid & mem_ready = 1; mem_ready = 1 iff queue_count < 4 and clr = 0 (combinational from state only, never from mem_valid).
REQ-019 Queue: in-order FIFO of {live, reg, data}; pushed entry live = 1 unless mem_reg = 0 (pushed killed).
REQ-020 Drain: with alu_valid = 0 and queue_count > 0, head pops at the edge; if head live, write = 1 next cycle with head reg/data, else write = 0; slot freed either way.
REQ-021 Mem latency, empty queue, no ALU traffic: accepted at edge N -> popped at edge N+1 -> write = 1 during cycle N+2.
REQ-022 Idle (no ALU, empty queue): write = 0; write_reg/write_data hold last value.
REQ-023 Kill rule: ALU result accepted at edge N for register r != 0 clears live on every entry already queued before edge N with reg = r; an entry pushed at the same edge N is not killed.
REQ-024 Simultaneous push and pop at one edge: both occur; queue_count unchanged.
REQ-025 Full: queue_count = 4 -> mem_ready = 0; mem_valid held without transfer; no entry overwritten.
REQ-026 Wrap-around: read/write pointers are 2-bit modulo-4; order preserved across wrap.
REQ-027 busy_mask derives combinationally from live entries only; killed entries never set bits.
REQ-028 Continuous alu_valid starves the queue indefinitely; no overflow, no data loss.

Reset
REQ-029 clr = 1 at an edge: write = 0, write_reg = 0, write_data = 0, queue emptied, queue_count = 0, busy_mask = 0, pointers = 0.
REQ-030 During clr = 1, mem_ready = 0 and no push occurs; clr mid-drain discards all queued entries with no write.
REQ-031 First cycle after clr deasserts: mem_ready = 1, write = 0.

Verification
REQ-032 ALU alu_valid=1, alu_reg=5, alu_data=0xDEADBEEF at edge 1 -> write=1, write_reg=5, write_data=0xDEADBEEF in cycle 2; write=0 in cycle 3.
REQ-033 Mem push reg=7, data=0x12345678 into empty queue, no ALU -> busy_mask=0x80 for one cycle, write=1 reg 7 two cycles after accept, busy_mask=0 after pop.
REQ-034 Push 4 mem entries (regs 1-4) with alu_valid=1 continuously -> mem_ready=0, queue_count=4; drop alu_valid -> four writes regs 1,2,3,4 on consecutive cycles, mem_ready returns 1 after first pop.
REQ-035 Queue holds reg 9 entry; ALU writes reg 9 data 0xAA -> write reg 9 0xAA; busy_mask bit 9 clears; later pop of killed entry gives write=0, queue_count decrements.
REQ-036 Mem push to reg 0 -> queue_count=1, busy_mask=0, pop yields write=0; ALU to reg 0 -> write=0.
REQ-037 Three entries queued, clr=1 one cycle -> queue_count=0, busy_mask=0, write=0; no later write of those entries.
